// File: rtl/residue_pkg.sv
// Shared types and elaboration helpers for the mod-(2^M-1) residue stream engine.
// The optional RESIDUE_CHECK_EN build adds an expected-residue compare in the top.
package residue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Legal when the chunk splits into whole M-bit digits and there is at least one chunk.
    function automatic bit params_ok(input int unsigned m, input int unsigned chunk_w,
                                     input int unsigned n_chunks);
        return (m >= 2) && (n_chunks >= 1) && (chunk_w >= m) && ((chunk_w % m) == 0);
    endfunction

    function automatic int unsigned mod_of(input int unsigned m);
        return (32'd1 << m) - 32'd1;
    endfunction

    function automatic int unsigned n_digits(input int unsigned w, input int unsigned m);
        return (w + m - 1) / m;
    endfunction

    // Wide enough for the plain digit sum and every end-around fold step after it.
    function automatic int unsigned fold_sum_w(input int unsigned w, input int unsigned m);
        return m + $clog2(n_digits(w, m)) + 1;
    endfunction

endpackage

// File: rtl/residue_fold.sv
// Combinational W-bit to M-bit mod-(2^M-1) reduction: digit sum with end-around carry,
// all-ones mapped to zero.
module residue_fold
    import residue_pkg::*;
#(
    parameter int unsigned W = 9,
    parameter int unsigned M = 3
) (
    input  logic [W-1:0] x,
    output logic [M-1:0] res_c
);

    localparam int unsigned ND  = n_digits(W, M);
    localparam int unsigned PW  = ND * M;
    localparam int unsigned SW  = fold_sum_w(W, M);
    localparam int unsigned MOD = mod_of(M);

    logic [PW-1:0] x_pad;
    logic [SW-1:0] sum;

    assign x_pad = PW'(x);

    // Each fold keeps the value congruent mod 2^M-1; SW passes always reach a fixed point.
    always_comb begin
        sum = '0;
        for (int i = 0; i < ND; i++) begin
            sum = sum + SW'(x_pad[i*M +: M]);
        end
        for (int k = 0; k < SW; k++) begin
            sum = SW'(sum[M-1:0]) + (sum >> M);
        end
        res_c = (sum[M-1:0] == M'(MOD)) ? '0 : sum[M-1:0];
    end

endmodule

// File: rtl/residue_stream_mod.sv
// Streaming mod-(2^M-1) residue engine: N_CHUNKS beats in, one held result out.
// Define RESIDUE_CHECK_EN to add Exp_in and the registered Mismatch flag.
module residue_stream_mod
    import residue_pkg::*;
#(
    parameter int unsigned M        = 3,
    parameter int unsigned CHUNK_W  = 6,
    parameter int unsigned N_CHUNKS = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [CHUNK_W-1:0] D_in,
    input  logic               D_valid,
    output logic               D_ready,
    output logic [M-1:0]       Res_out,
    output logic               Res_valid,
    input  logic               Res_ack,
    output logic               Busy
`ifdef RESIDUE_CHECK_EN
    ,
    input  logic [M-1:0]       Exp_in,
    output logic               Mismatch
`endif
);

    localparam int unsigned CW = $clog2(N_CHUNKS + 1);
    localparam int unsigned FW = CHUNK_W + M;

    if (!params_ok(M, CHUNK_W, N_CHUNKS)) begin : g_param_err
        $error("residue_stream_mod: illegal parameters M=%0d CHUNK_W=%0d N_CHUNKS=%0d",
               M, CHUNK_W, N_CHUNKS);
    end

    state_t        state;
    logic [M-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [M-1:0]  fold_res_c;
    logic          beat_c;
    logic          last_c;

    // acc sits above the chunk; 2^CHUNK_W == 1 mod 2^M-1, so this is acc + chunk.
    residue_fold #(
        .W (FW),
        .M (M)
    ) u_fold (
        .x     ({acc, D_in}),
        .res_c (fold_res_c)
    );

    assign beat_c = D_valid && D_ready;
    assign last_c = (cnt == CW'(N_CHUNKS - 1));

    // D_ready and Busy are registered decodes of the next state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            Res_out   <= '0;
            Res_valid <= 1'b0;
            D_ready   <= 1'b0;
            Busy      <= 1'b0;
`ifdef RESIDUE_CHECK_EN
            Mismatch  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        cnt     <= '0;
                        D_ready <= 1'b1;
                        Busy    <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat_c) begin
                        if (last_c) begin
                            state     <= DONE;
                            Res_out   <= fold_res_c;
                            Res_valid <= 1'b1;
                            D_ready   <= 1'b0;
`ifdef RESIDUE_CHECK_EN
                            Mismatch  <= (fold_res_c != Exp_in);
`endif
                        end else begin
                            acc <= fold_res_c;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (Res_ack) begin
                        Res_valid <= 1'b0;
`ifdef RESIDUE_CHECK_EN
                        Mismatch  <= 1'b0;
`endif
                        if (Start) begin
                            state   <= ACCUM;
                            acc     <= '0;
                            cnt     <= '0;
                            D_ready <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            D_ready <= 1'b0;
                            Busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    Res_valid <= 1'b0;
                    D_ready   <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
